bus_arbiter: RTL and testbench

- Shares the single 16-bit address / 8-bit data system bus between two masters: M0 (CPU, default owner) and M1 (secondary master, e.g. DMA or loader).
- Sequences each transfer with a programmable wait-state count and generates the RAM and diode-port chip selects from the granted address.
- Sits between the masters and the RAM/peripheral decode. The top level builds the tristate data_bus from bus_wdata/bus_rdata.

---
 rtl/bus_arbiter_pkg.sv | 23 ++
 rtl/bus_arbiter_decode.sv | 19 +
 rtl/bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and decode constants for the two-master system bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OWN0 = 3'd1,
        OWN1 = 3'd2,
        XFER = 3'd3,
        HAND = 3'd4
    } arb_state_e;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } master_e;

    localparam int         ADDR_W        = 16;
    localparam int         DATA_W        = 8;
    localparam int         RAM_BIT       = 15;       // RAM lives where this bit is clear
    localparam logic [3:0] DIODES_HI     = 4'b1001;
    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/bus_arbiter_decode.sv
// Combinational address decode: chip-select hits and the wait-state count for a transfer.
module bus_decode
    import bus_arbiter_pkg::*;
#(
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit_ram,
    output logic              hit_diodes,
    output logic [2:0]        wait_cycles
);

    assign hit_ram     = !addr[RAM_BIT];
    assign hit_diodes  = (addr[15:12] == DIODES_HI);
    // Unmapped addresses take the I/O timing.
    assign wait_cycles = hit_ram ? 3'(RAM_WAIT) : 3'(IO_WAIT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 16/8 system bus for M0 (CPU) and M1 (DMA/loader),
// sequencing wait-stated transfers and generating RAM / diode-port selects.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int RAM_WAIT  = 1,
    parameter int IO_WAIT   = 0,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m0_read,
    input  logic              m1_read,
    input  logic              m0_write,
    input  logic              m1_write,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_ready,
    output logic              m1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic              cs_ram,
    output logic              cs_diodes
);

    arb_state_e        state, state_n;
    master_e           owner, owner_n, last_owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_read;
    logic [2:0]        wait_cnt;
    logic [7:0]        burst_cnt, burst_inc;
    logic              burst_full, last_xfer;

    logic              cur_req, oth_req, cur_rd, cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              hit_ram, hit_diodes;
    logic [2:0]        dec_wait;

    // Decoding bus_addr covers both cases: it mirrors the owner's address in OWNx
    // (wait-count load) and the latched address in XFER (chip selects, rdata).
    bus_decode #(.RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT)) u_decode (
        .addr        (bus_addr),
        .hit_ram     (hit_ram),
        .hit_diodes  (hit_diodes),
        .wait_cycles (dec_wait)
    );

    always_comb begin
        cur_req   = (owner == MST1) ? m1_req   : m0_req;
        oth_req   = (owner == MST1) ? m0_req   : m1_req;
        cur_rd    = (owner == MST1) ? m1_read  : m0_read;
        cur_wr    = (owner == MST1) ? m1_write : m0_write;
        cur_addr  = (owner == MST1) ? m1_addr  : m0_addr;
        cur_wdata = (owner == MST1) ? m1_wdata : m0_wdata;
    end

    assign last_xfer  = (state == XFER) && (wait_cnt == 3'd0);
    assign burst_inc  = (burst_cnt < 8'(MAX_BURST)) ? burst_cnt + 8'd1 : burst_cnt;
    assign burst_full = (burst_inc == 8'(MAX_BURST));

    // Bus drive: idle and hand-over cycles park the bus at zero.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        case (state)
            OWN0, OWN1: begin
                bus_addr  = cur_addr;
                bus_wdata = cur_wdata;
            end
            XFER: begin
                bus_addr  = lat_addr;
                bus_wdata = lat_wdata;
                bus_read  = lat_read;
                bus_write = !lat_read;
            end
            default: ;
        endcase
    end

    assign cs_ram    = (bus_read || bus_write) && hit_ram;
    assign cs_diodes = (bus_read || bus_write) && hit_diodes;
    assign m0_gnt    = (state == OWN0) || ((state == XFER) && (owner == MST0));
    assign m1_gnt    = (state == OWN1) || ((state == XFER) && (owner == MST1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= MST0;
        end else begin
            state <= state_n;
            owner <= owner_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || last_owner == MST1)) begin
                    state_n = OWN0;
                    owner_n = MST0;
                end else if (m1_req) begin
                    state_n = OWN1;
                    owner_n = MST1;
                end
            end
            OWN0, OWN1: begin
                if (cur_rd || cur_wr)
                    state_n = XFER;
                else if (!cur_req)
                    state_n = HAND;
            end
            XFER: begin
                if (last_xfer) begin
                    if (!cur_req || (burst_full && oth_req))
                        state_n = HAND;
                    else
                        state_n = (owner == MST1) ? OWN1 : OWN0;
                end
            end
            HAND:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= MST1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_read   <= 1'b0;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
            rdata      <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                OWN0, OWN1: begin
                    if (cur_rd || cur_wr) begin
                        lat_addr  <= cur_addr;
                        lat_wdata <= cur_wdata;
                        lat_read  <= cur_rd;   // read wins if both strobes are high
                        wait_cnt  <= dec_wait;
                    end
                end
                XFER: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        if (lat_read)
                            rdata <= (hit_ram || hit_diodes) ? bus_rdata : UNMAPPED_DATA;
                        m0_ready  <= (owner == MST0);
                        m1_ready  <= (owner == MST1);
                        // An uncontested full burst restarts the count without losing the bus.
                        burst_cnt <= (burst_full && !oth_req) ? 8'd0 : burst_inc;
                    end
                end
                HAND: begin
                    last_owner <= owner;
                    burst_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small RAM / diode-port model on the system bus.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_read, m1_read, m0_write, m1_write;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_ready, m1_ready;
    logic [7:0]  rdata, bus_wdata, bus_rdata;
    logic [15:0] bus_addr;
    logic        bus_read, bus_write, cs_ram, cs_diodes;

    logic [7:0]  ram [0:255];
    logic [7:0]  led;
    logic        mem_init;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.RAM_WAIT(1), .IO_WAIT(0), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_read(m0_read), .m1_read(m1_read),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_ready(m0_ready), .m1_ready(m1_ready),
        .rdata(rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_read(bus_read), .bus_write(bus_write),
        .cs_ram(cs_ram), .cs_diodes(cs_diodes)
    );

    function automatic logic [7:0] ram_init(input int k);
        return (k == 16) ? 8'hA5 : 8'(k * 3 + 7);
    endfunction

    // Memory model: filled on the first clock edge, written by selected write strobes.
    always @(posedge clk) begin
        if (mem_init !== 1'b1) begin
            for (int k = 0; k < 256; k++) ram[k] <= ram_init(k);
            led      <= 8'h00;
            mem_init <= 1'b1;
        end else begin
            if (cs_ram && bus_write)    ram[bus_addr[7:0]] <= bus_wdata;
            if (cs_diodes && bus_write) led <= bus_wdata;
        end
    end

    assign bus_rdata = cs_ram ? ram[bus_addr[7:0]] : (cs_diodes ? led : 8'h00);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        {m0_req, m1_req, m0_read, m1_read, m0_write, m1_write} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        tick(); tick();

        chk1 ("rst_m0_gnt",   m0_gnt,   1'b0);
        chk1 ("rst_m1_gnt",   m1_gnt,   1'b0);
        chk1 ("rst_m0_ready", m0_ready, 1'b0);
        chk8 ("rst_rdata",    rdata,    8'h00);
        chk16("rst_bus_addr", bus_addr, 16'h0000);
        chk1 ("rst_bus_read", bus_read, 1'b0);
        chk1 ("rst_cs_ram",   cs_ram,   1'b0);

        // Single requester is granted one edge after reset release.
        m0_req = 1'b1; m0_addr = 16'h0010;
        reset = 1'b1;
        tick();
        chk1 ("grant_m0",      m0_gnt,   1'b1);
        chk1 ("grant_m1_off",  m1_gnt,   1'b0);
        chk16("own_addr",      bus_addr, 16'h0010);
        chk1 ("own_no_strobe", bus_read, 1'b0);

        // RAM read: two XFER cycles, ready with data on the third.
        m0_read = 1'b1;
        tick();
        chk1("rd_bus_read", bus_read, 1'b1);
        chk1("rd_cs_ram_1", cs_ram,   1'b1);
        chk1("rd_ready_1",  m0_ready, 1'b0);
        m0_read = 1'b0;
        tick();
        chk1("rd_cs_ram_2", cs_ram,   1'b1);
        chk1("rd_ready_2",  m0_ready, 1'b0);
        tick();
        chk1("rd_ready",    m0_ready, 1'b1);
        chk8("rd_rdata",    rdata,    8'hA5);
        chk1("rd_cs_done",  cs_ram,   1'b0);
        tick();
        chk1("rd_ready_pulse", m0_ready, 1'b0);

        // Diode-port write: zero wait states.
        m0_addr = 16'h9000; m0_wdata = 8'h3C; m0_write = 1'b1;
        tick();
        chk1("wr_bus_write", bus_write, 1'b1);
        chk1("wr_cs_diodes", cs_diodes, 1'b1);
        chk1("wr_cs_ram",    cs_ram,    1'b0);
        chk8("wr_bus_wdata", bus_wdata, 8'h3C);
        m0_write = 1'b0;
        tick();
        chk1("wr_ready",     m0_ready,  1'b1);
        chk1("wr_strobe_off", bus_write, 1'b0);
        chk8("wr_led",       led,       8'h3C);
        chk8("wr_rdata_keep", rdata,    8'hA5);

        // Unmapped read returns FF with no chip select.
        m0_addr = 16'h8000; m0_read = 1'b1;
        tick();
        chk1("um_bus_read", bus_read,  1'b1);
        chk1("um_cs_ram",   cs_ram,    1'b0);
        chk1("um_cs_diod",  cs_diodes, 1'b0);
        m0_read = 1'b0;
        tick();
        chk1("um_ready", m0_ready, 1'b1);
        chk8("um_rdata", rdata,    8'hFF);

        // Fresh reset, both request: M0 first, hand-over to M1 on release.
        reset = 1'b0; m0_req = 1'b0;
        tick();
        chk8("rst2_rdata", rdata, 8'h00);
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 16'h0020;
        reset = 1'b1;
        tick();
        chk1("both_m0_gnt", m0_gnt, 1'b1);
        chk1("both_m1_gnt", m1_gnt, 1'b0);
        m0_req = 1'b0;
        tick();
        chk1("hand_m0_gnt", m0_gnt, 1'b0);
        chk1("hand_m1_gnt", m1_gnt, 1'b0);
        tick();
        chk1("idle_m1_gnt", m1_gnt, 1'b0);
        tick();
        chk1 ("ho_m1_gnt",   m1_gnt,   1'b1);
        chk1 ("ho_m0_gnt",   m0_gnt,   1'b0);
        chk16("ho_bus_addr", bus_addr, 16'h0020);

        // M1 releases; then a contested 8-read burst by M0.
        m1_req = 1'b0;
        tick(); tick();
        m0_req = 1'b1; m0_read = 1'b1; m0_addr = 16'h0040; m1_req = 1'b1;
        tick();
        chk1("burst_grant", m0_gnt, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("burst_busy", m0_ready, 1'b0);
            tick(); tick();
            chk1("burst_ready", m0_ready, 1'b1);
            chk8("burst_rdata", rdata, ram_init(16'h0040 + i));
            chk1("burst_gnt", m0_gnt, (i < 7) ? 1'b1 : 1'b0);
            m0_addr = 16'(16'h0041 + i);
        end
        chk1("burst_hand_m1", m1_gnt, 1'b0);
        m0_read = 1'b0;
        tick();
        chk1("burst_idle_m1", m1_gnt, 1'b0);
        tick();
        chk1("burst_m1_gnt", m1_gnt, 1'b1);
        chk1("burst_m0_off", m0_gnt, 1'b0);
        m1_req = 1'b0;
        tick(); tick(); tick();
        chk1("regrant_m0", m0_gnt, 1'b1);

        // Reset in the middle of a RAM write XFER.
        m0_addr = 16'h0030; m0_wdata = 8'h77; m0_write = 1'b1;
        tick();
        chk1("mx_bus_write", bus_write, 1'b1);
        chk1("mx_cs_ram",    cs_ram,    1'b1);
        m0_write = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk1("mx_write_drop", bus_write, 1'b0);
        chk1("mx_cs_drop",    cs_ram,    1'b0);
        chk1("mx_gnt_drop",   m0_gnt,    1'b0);
        m0_req = 1'b0;
        tick();
        chk1("mx_no_ready_1", m0_ready, 1'b0);
        tick();
        chk1("mx_no_ready_2", m0_ready, 1'b0);
        reset = 1'b1;
        tick();
        chk1 ("mx_idle_gnt",  m0_gnt,   1'b0);
        chk16("mx_idle_addr", bus_addr, 16'h0000);
        chk8 ("mx_ram_kept",  ram[8'h30], ram_init(16'h0030));
        m0_req = 1'b1;
        tick();
        chk1("mx_regrant", m0_gnt, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
